// File: rtl/sym_pack_2to8.sv
// -----------------------------------------------------------------------------
// sym_pack_2to8
//
// Packs a stream of 2-bit symbols into bytes, first symbol in the MSBs.
// Up to three symbols are held in a collector; the fourth completes a byte,
// which is moved into a single output register with a valid/ready handshake.
// A flush request pushes out a partial byte (zero-padded low bits) together
// with its symbol count.
//
// Ports
//   clk        in   1  rising-edge clock
//   clr        in   1  asynchronous active-high reset
//   in_valid   in   1  in_sym holds a valid symbol
//   in_sym     in   2  incoming symbol
//   in_ready   out  1  a symbol is accepted this cycle if in_valid is high
//   flush      in   1  single-cycle request to emit the partial byte
//   out_valid  out  1  out_byte/out_len hold an unconsumed byte
//   out_byte   out  8  packed byte, first symbol in [7:6]
//   out_len    out  3  number of valid symbols in out_byte (1..4)
//   out_ready  in   1  downstream consumes the byte this cycle
// -----------------------------------------------------------------------------
module sym_pack_2to8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic [2:0] out_len,
    input  logic       out_ready
);

    // Collector holds symbols 1..3 MSB-first; bits below cnt are always zero.
    logic [5:0] coll_q, coll_d;
    logic [1:0] cnt_q, cnt_d;
    logic       flush_pend_q, flush_pend_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic [2:0] out_len_q, out_len_d;

    logic       out_free;
    logic       accept;
    logic       pend_eff;
    logic       load;
    logic [2:0] n_sym;
    logic [7:0] byte_w;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        // The output register can take a new byte when it is empty or is
        // being drained on this very edge.
        out_free = !out_valid_q || out_ready;

        // Stall only when accepting would require a load that cannot happen:
        // a 4th symbol, or any symbol while a flush is waiting for room.
        // Nothing is accepted while clr is asserted.
        in_ready = !clr && (out_free || (cnt_q != 2'd3 && !flush_pend_q));
        accept   = in_valid && in_ready;

        // A flush arriving this cycle is serviced immediately if possible.
        pend_eff = flush_pend_q || flush;

        // Collector contents with the accepted symbol merged in at slot cnt.
        byte_w = {coll_q, 2'b00};
        if (accept) begin
            case (cnt_q)
                2'd0:    byte_w[7:6] = in_sym;
                2'd1:    byte_w[5:4] = in_sym;
                2'd2:    byte_w[3:2] = in_sym;
                default: byte_w[1:0] = in_sym;
            endcase
        end
        n_sym = {1'b0, cnt_q} + {2'b00, accept};

        // Load on a completed byte, or on a flush with at least one symbol.
        load = out_free && ((n_sym == 3'd4) || (pend_eff && (n_sym != 3'd0)));

        coll_d       = coll_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        out_len_d    = out_len_q;

        if (load) begin
            out_valid_d  = 1'b1;
            out_byte_d   = byte_w;
            out_len_d    = n_sym;
            coll_d       = 6'd0;
            cnt_d        = 2'd0;
            flush_pend_d = 1'b0;
        end else begin
            out_valid_d  = out_valid_q && !out_ready;
            coll_d       = byte_w[7:2];
            cnt_d        = n_sym[1:0];
            // An empty flush serviced with room available just retires.
            flush_pend_d = pend_eff && !out_free;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values; every register, datapath included, is cleared by clr
    // so a partial or held byte never survives a reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            coll_q       <= 6'd0;
            cnt_q        <= 2'd0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            out_len_q    <= 3'd0;
        end else begin
            coll_q       <= coll_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_len_q    <= out_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_len   = out_len_q;

endmodule

// File: tb/tb_sym_pack_2to8.sv
// -----------------------------------------------------------------------------
// tb_sym_pack_2to8
//
// Directed scenarios plus a long random run. Every accepted symbol is queued
// by a monitor; every consumed byte must reproduce the queued symbols in
// order (out_len of them, MSB-first, zero padding below). A held byte must
// stay unchanged until consumed.
// -----------------------------------------------------------------------------
module tb_sym_pack_2to8;

    logic       clk = 1'b0;
    logic       clr;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_byte;
    logic [2:0] out_len;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    int sb_q[$];
    logic       hold_v;
    logic [7:0] hold_byte;
    logic [2:0] hold_len;

    sym_pack_2to8 dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sym    (in_sym),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_len   (out_len),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, return just after the rising edge.
    task automatic cyc(input logic v, input logic [1:0] s, input logic f, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_sym    = s;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr       = 1'b1;
        in_valid  = 1'b0;
        in_sym    = 2'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        hold_v    = 1'b0;
        hold_byte = 8'h00;
        hold_len  = 3'd0;

        fork
            // Monitor / scoreboard: samples 1 time unit before each rising edge.
            forever begin
                @(negedge clk or posedge clr);
                if (clr) begin
                    sb_q.delete();
                    hold_v = 1'b0;
                end else begin
                    #4;
                    if (!clr) begin
                        if (hold_v) begin
                            check("hold_valid", int'(out_valid), 1);
                            check("hold_byte", int'(out_byte), int'(hold_byte));
                            check("hold_len", int'(out_len), int'(hold_len));
                        end
                        if (out_valid && out_ready) begin
                            check("out_len_range", int'(out_len >= 3'd1 && out_len <= 3'd4), 1);
                            for (int i = 0; i < int'(out_len) && i < 4; i++) begin
                                if (sb_q.size() == 0) begin
                                    check("sb_has_symbol", 0, 1);
                                end else begin
                                    check("sym", int'((out_byte >> (6 - 2 * i)) & 8'h03),
                                          sb_q.pop_front());
                                end
                            end
                            if (out_len < 3'd4)
                                check("pad_zero", int'(out_byte & (8'hFF >> (2 * out_len))), 0);
                        end
                        hold_v    = out_valid && !out_ready;
                        hold_byte = out_byte;
                        hold_len  = out_len;
                        if (in_valid && in_ready)
                            sb_q.push_back(int'(in_sym));
                    end
                end
            end

            begin
                // Reset state while clr is held.
                #12;
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_byte", int'(out_byte), 8'h00);
                check("rst_out_len", int'(out_len), 0);
                check("rst_in_ready", int'(in_ready), 0);
                @(negedge clk);
                clr = 1'b0;
                #1;
                check("idle_in_ready", int'(in_ready), 1);

                // Full byte 3,0,2,1 -> C9.
                cyc(1, 2'd3, 0, 1); cyc(1, 2'd0, 0, 1); cyc(1, 2'd2, 0, 1); cyc(1, 2'd1, 0, 1);
                check("c9_valid", int'(out_valid), 1);
                check("c9_byte", int'(out_byte), 8'hC9);
                check("c9_len", int'(out_len), 4);
                cyc(0, 2'd0, 0, 1);
                check("c9_consumed", int'(out_valid), 0);

                // 1,2 then flush -> 60/2, then a full byte proves cnt restarted.
                cyc(1, 2'd1, 0, 1); cyc(1, 2'd2, 0, 1); cyc(0, 2'd0, 1, 1);
                check("f60_byte", int'(out_byte), 8'h60);
                check("f60_len", int'(out_len), 2);
                cyc(1, 2'd3, 0, 1); cyc(1, 2'd3, 0, 1); cyc(1, 2'd3, 0, 1); cyc(1, 2'd3, 0, 1);
                check("ff_byte", int'(out_byte), 8'hFF);
                check("ff_len", int'(out_len), 4);
                cyc(0, 2'd0, 0, 1);

                // Symbol and flush on the same edge: 2 then (3+flush) -> B0/2.
                cyc(1, 2'd2, 0, 1); cyc(1, 2'd3, 1, 1);
                check("fb0_byte", int'(out_byte), 8'hB0);
                check("fb0_len", int'(out_len), 2);
                cyc(0, 2'd0, 0, 1);

                // Empty flush emits nothing and does not linger.
                cyc(0, 2'd0, 1, 1);
                check("empty_flush_valid", int'(out_valid), 0);
                cyc(1, 2'd1, 0, 1); cyc(0, 2'd0, 0, 1); cyc(0, 2'd0, 0, 1);
                check("empty_flush_retired", int'(out_valid), 0);
                cyc(0, 2'd0, 1, 1);
                check("f40_byte", int'(out_byte), 8'h40);
                check("f40_len", int'(out_len), 1);
                cyc(0, 2'd0, 0, 1);

                // Backpressure: C9 held, three more symbols, stall at cnt=3.
                cyc(1, 2'd3, 0, 0); cyc(1, 2'd0, 0, 0); cyc(1, 2'd2, 0, 0); cyc(1, 2'd1, 0, 0);
                check("bp_c9_byte", int'(out_byte), 8'hC9);
                cyc(1, 2'd1, 0, 0); cyc(1, 2'd1, 0, 0); cyc(1, 2'd1, 0, 0);
                check("bp_in_ready_low", int'(in_ready), 0);
                cyc(1, 2'd1, 0, 0);
                check("bp_still_c9", int'(out_byte), 8'hC9);
                @(negedge clk);
                in_sym    = 2'd2;
                out_ready = 1'b1;
                #1;
                check("bp_in_ready_high", int'(in_ready), 1);
                @(posedge clk);
                #1;
                check("bp_56_valid", int'(out_valid), 1);
                check("bp_56_byte", int'(out_byte), 8'h56);
                check("bp_56_len", int'(out_len), 4);
                cyc(0, 2'd0, 0, 1);

                // clr between edges with a held byte and cnt=2.
                cyc(1, 2'd1, 0, 0); cyc(1, 2'd1, 0, 0); cyc(1, 2'd1, 0, 0); cyc(1, 2'd1, 0, 0);
                cyc(1, 2'd2, 0, 0); cyc(1, 2'd2, 0, 0);
                check("pre_clr_valid", int'(out_valid), 1);
                in_valid = 1'b0;
                #1;
                clr = 1'b1;
                #1;
                check("clr_out_valid", int'(out_valid), 0);
                check("clr_out_byte", int'(out_byte), 8'h00);
                check("clr_out_len", int'(out_len), 0);
                clr = 1'b0;
                cyc(1, 2'd0, 0, 1); cyc(1, 2'd1, 0, 1); cyc(1, 2'd2, 0, 1); cyc(1, 2'd3, 0, 1);
                check("post_clr_byte", int'(out_byte), 8'h1B);
                check("post_clr_len", int'(out_len), 4);
                cyc(0, 2'd0, 0, 1);

                // Random traffic against the symbol-stream scoreboard.
                for (int c = 0; c < 10000; c++) begin
                    cyc(($urandom % 4) != 0, 2'($urandom), ($urandom % 16) == 0,
                        ($urandom % 3) != 0);
                end

                // Drain: flush the remainder and let everything be consumed.
                cyc(0, 2'd0, 1, 1);
                cyc(0, 2'd0, 0, 1); cyc(0, 2'd0, 0, 1); cyc(0, 2'd0, 0, 1);
                check("drain_empty", sb_q.size(), 0);
                check("drain_out_valid", int'(out_valid), 0);

                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join
    end

endmodule

// File: doc/sym_pack_2to8.md
SYM_PACK_2TO8 -- requirements
Module: sym_pack_2to8

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1, reset: asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, upstream 2-bit register output holds a valid symbol.
REQ-004 SHALL have port in_sym, input, 2, symbol taken from upstream 2-bit register q.
REQ-005 SHALL have port in_ready, output, 1, block can accept a symbol this cycle.
REQ-006 SHALL have port flush, input, 1, single-cycle request to emit a partial byte.
REQ-007 SHALL have port out_valid, output, 1, out_byte/out_len hold an unconsumed byte.
REQ-008 SHALL have port out_byte, output, 8, packed byte.
REQ-009 SHALL have port out_len, output, 3, number of valid symbols in out_byte (1..4).
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the byte this cycle.

Function
REQ-011 SHALL accept a symbol when in_valid and in_ready are both 1 at a rising edge.
REQ-012 SHALL pack symbols MSB-first: 1st symbol in [7:6], 2nd in [5:4], 3rd in [3:2], 4th in [1:0].
REQ-013 SHALL keep a collector register (6 bits) and a symbol count cnt (0..3).
REQ-014 SHALL transfer a full byte, out_len=4, into the output register on the edge accepting the 4th symbol; cnt returns to 0.
REQ-015 SHALL treat the output register as free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 SHALL drive in_ready=0 only when cnt=3 and the output register is not free; in_ready is a combinational function of state and out_ready.
REQ-017 SHALL clear out_valid on an edge with out_ready=1 and out_valid=1 unless a new byte loads on that same edge, in which case out_valid stays 1.
REQ-018 SHALL hold out_byte and out_len stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, on flush, set a flush_pending flag that persists until serviced; a flush with flush_pending already set is absorbed.
REQ-020 SHALL service flush_pending on the first edge where the output register is free: emit collector contents padded with zeros in the unused low bits, out_len=cnt, cnt to 0, flag cleared.
REQ-021 SHALL, when flush_pending and in_valid are both active on the same servicing edge, include the accepted symbol first, then flush (e.g. cnt=1 plus symbol gives out_len=2).
REQ-022 SHALL, when accepting a 4th symbol and flush_pending on the same edge, emit the full byte with out_len=4 and clear flush_pending.
REQ-023 SHALL clear flush_pending without emitting anything when serviced with cnt=0 and no symbol accepted.
REQ-024 SHALL drive in_ready=0 while flush_pending is set and the output register is not free, so no symbol is accepted between request and service.
REQ-025 SHALL never drop or duplicate a symbol or byte under any combination of in_valid, flush, out_ready.

Reset
REQ-026 SHALL, on clr=1 asynchronously and regardless of clk, set cnt=0, collector=0, flush_pending=0, out_valid=0, out_byte=8'h00, out_len=3'd0.
REQ-027 SHALL drive in_ready=1 while clr=1 is released and the block is idle, and accept no symbol on any edge while clr=1.
REQ-028 SHALL discard a partially collected byte and any held output byte when clr asserts mid-operation.

Verification
REQ-029 Symbols 3,0,2,1 on four consecutive cycles with out_ready=1 -> out_valid=1 next cycle, out_byte=8'hC9, out_len=4.
REQ-030 Symbols 1,2 then flush -> out_byte=8'h60, out_len=2, cnt=0 afterwards.
REQ-031 out_ready=0 holding 8'hC9, three more symbols collected -> in_ready=0 at cnt=3; out_ready=1 -> 4th symbol accepted same cycle, no loss.
REQ-032 flush at cnt=0 with in_valid=0 -> no out_valid pulse, flush_pending cleared.
REQ-033 clr=1 pulsed between clk edges at cnt=2 with out_valid=1 -> out_valid=0, out_byte=8'h00 immediately; next 4 symbols form a fresh byte.
REQ-034 Random in_valid/out_ready/flush for 10k cycles against a scoreboard -> symbol stream in equals concatenated out_len-truncated bytes out.
